// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline
// Optional HAZARD_PERF_EN adds saturating stall_cycles / flush_events counters.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic       branchD,
  input  logic       pcsrcD,
  input  logic       jumpD,
  input  logic [4:0] rtE,
  input  logic [4:0] writeregE,
  input  logic       RegWriteE,
  input  logic       MemtoRegE,
  input  logic       divstartE,
  input  logic       divdoneE,
  input  logic [4:0] writeregM,
  input  logic       MemtoRegM,
  input  logic       memreqM,
  input  logic       memreadyM,
  input  logic       excM,
  output logic       stallF,
  output logic       stallD,
  output logic       stallE,
  output logic       stallM,
  output logic       flushD,
  output logic       flushE,
  output logic       flushM,
  output logic       flushW,
  output logic       mem_err
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, DIV = 2'd1, MEM = 2'd2} state_t;

  localparam logic [CNT_W-1:0] WCNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t           state, stateNext;
  logic [CNT_W-1:0] wcnt, wcntNext;
  logic             memErrNext;

  logic memWait, divBusy, lwStall, brStall, hazStall;

  // A wait raised while the divider is busy borrows the MEM outputs without leaving DIV.
  always_comb begin
    memWait = ((state != MEM) && memreqM && !memreadyM) ||
              ((state == MEM) && !memreadyM);
    divBusy = ((state == IDLE) && divstartE && !divdoneE && !memWait) ||
              ((state == DIV) && !divdoneE);
    lwStall = MemtoRegE && (rtE != 5'd0) && ((rtE == rsD) || (rtE == rtD));
    brStall = branchD &&
              ((RegWriteE && (writeregE != 5'd0) &&
                ((writeregE == rsD) || (writeregE == rtD))) ||
               (MemtoRegM && (writeregM != 5'd0) &&
                ((writeregM == rsD) || (writeregM == rtD))));
    hazStall = lwStall || brStall;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      wcnt    <= '0;
      mem_err <= 1'b0;
    end else begin
      state   <= stateNext;
      wcnt    <= wcntNext;
      mem_err <= memErrNext;
    end
  end

  always_comb begin
    stateNext  = state;
    wcntNext   = wcnt;
    memErrNext = 1'b0;
    if (excM) begin
      stateNext = IDLE;
      wcntNext  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (memreqM && !memreadyM) begin
            stateNext = MEM;
            wcntNext  = CNT_W'(1);
          end else if (divstartE && !divdoneE) begin
            stateNext = DIV;
          end
        end
        MEM: begin
          if (memreadyM) begin
            stateNext = IDLE;
            wcntNext  = '0;
          end else if (wcnt == WCNT_LAST) begin
            stateNext  = IDLE;
            wcntNext   = '0;
            memErrNext = 1'b1;
          end else begin
            wcntNext = wcnt + CNT_W'(1);
          end
        end
        DIV: begin
          if (divdoneE) stateNext = IDLE;
        end
        default: begin
          stateNext = IDLE;
          wcntNext  = '0;
        end
      endcase
    end
  end

  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    stallM = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    flushM = 1'b0;
    flushW = 1'b0;
    if (!reset) begin
      stallF = 1'b0;
    end else if (excM) begin
      flushD = 1'b1;
      flushE = 1'b1;
      flushM = 1'b1;
      flushW = 1'b1;
    end else if (memWait) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      stallM = 1'b1;
      flushW = 1'b1;
    end else if (divBusy) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      flushM = 1'b1;
    end else if (hazStall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      flushE = 1'b1;
    end else if (pcsrcD || jumpD) begin
      flushD = 1'b1;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (stallF && (stall_cycles != 32'hFFFF_FFFF))
        stall_cycles <= stall_cycles + 32'd1;
      if ((flushD || flushE || flushM || flushW) && (flush_events != 32'hFFFF_FFFF))
        flush_events <= flush_events + 32'd1;
    end
  end
`endif

endmodule
